// File: rtl/mul_pkg.sv
// rtl/mul_pkg.sv - shared FSM encoding and iteration helpers for seq_mul
//
// Contents:
//   state_t    : controller states IDLE / BUSY / DONE
//   iter_count : number of BUSY cycles for one product (WIDTH/STEP)
//   cnt_width  : bits needed to hold iter_count down to zero

package mul_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int iter_count(input int width, input int step);
        return width / step;
    endfunction

    function automatic int cnt_width(input int width, input int step);
        return $clog2(width / step + 1);
    endfunction

endpackage

// File: rtl/mul_step.sv
// rtl/mul_step.sv - one combinational shift-and-add step of the iterative multiplier
//
// Ports:
//   acc      in  2*WIDTH  running accumulator
//   mcand    in  WIDTH    unsigned multiplicand (magnitude)
//   bits     in  STEP     multiplier bits for this position
//   pos      in  POS_W    bit position of those multiplier bits
//   acc_next out 2*WIDTH  acc + (mcand * bits) << pos

module mul_step #(
    parameter int WIDTH = 32,
    parameter int STEP  = 1,
    parameter int POS_W = $clog2(2 * WIDTH)
) (
    input  logic [2*WIDTH-1:0] acc,
    input  logic [WIDTH-1:0]   mcand,
    input  logic [STEP-1:0]    bits,
    input  logic [POS_W-1:0]   pos,
    output logic [2*WIDTH-1:0] acc_next
);

    logic [2*WIDTH-1:0] partial;

    // mcand*bits < 2^(WIDTH+STEP) and pos <= WIDTH-STEP, so the shifted
    // partial product never spills past 2*WIDTH bits.
    assign partial  = (2*WIDTH)'(mcand) * (2*WIDTH)'(bits);
    assign acc_next = acc + (partial << pos);

endmodule

// File: rtl/seq_mul.sv
// rtl/seq_mul.sv - iterative signed/unsigned multiplier with valid/ready handshakes
//
// Ports:
//   clk, rst_n           clock, synchronous active-low reset
//   in_valid, in_ready   operand handshake (ready only in IDLE)
//   x, y, signed_mode    operands, sampled on the accepting edge only
//   out_valid, out_ready product handshake (valid only in DONE)
//   s, ovf               2*WIDTH product and does-not-fit-in-WIDTH flag;
//                        held until the next result completes

module seq_mul
    import mul_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int STEP  = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   x,
    input  logic [WIDTH-1:0]   y,
    input  logic               signed_mode,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] s,
    output logic               ovf
);

    localparam int ITER = iter_count(WIDTH, STEP);
    localparam int CW   = cnt_width(WIDTH, STEP);
    localparam int PW   = $clog2(2 * WIDTH);

    state_t             state, state_next;
    logic [CW-1:0]      cnt;
    logic [WIDTH-1:0]   mcand, mplier;
    logic [WIDTH-1:0]   x_mag, y_mag;
    logic [2*WIDTH-1:0] acc, acc_next, result;
    logic [WIDTH:0]     sign_field;
    logic [PW-1:0]      pos;
    logic               neg, smode, accept, last, ovf_next;

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_next = BUSY;
            end
            BUSY: begin
                if (cnt == CW'(1)) state_next = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign accept = in_valid && in_ready;
    assign last   = (state == BUSY) && (cnt == CW'(1));

    // The array works on magnitudes; -2^(W-1) negates to itself, which
    // read as unsigned is exactly its magnitude.
    assign x_mag = (signed_mode && x[WIDTH-1]) ? -x : x;
    assign y_mag = (signed_mode && y[WIDTH-1]) ? -y : y;

    // The counter runs down from ITER, so the retired multiplier bit
    // position is (ITER - cnt) * STEP.
    assign pos = PW'((ITER - int'(cnt)) * STEP);

    mul_step #(
        .WIDTH (WIDTH),
        .STEP  (STEP),
        .POS_W (PW)
    ) u_step (
        .acc      (acc),
        .mcand    (mcand),
        .bits     (mplier[STEP-1:0]),
        .pos      (pos),
        .acc_next (acc_next)
    );

    assign result     = neg ? -acc_next : acc_next;
    assign sign_field = result[2*WIDTH-1:WIDTH-1];
    // Signed: fits only when the upper half is a pure sign extension of bit W-1.
    assign ovf_next   = smode ? !((sign_field == '0) || (sign_field == '1))
                              : |result[2*WIDTH-1:WIDTH];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt    <= '0;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            neg    <= 1'b0;
            smode  <= 1'b0;
            s      <= '0;
            ovf    <= 1'b0;
        end else if (accept) begin
            mcand  <= x_mag;
            mplier <= y_mag;
            neg    <= signed_mode & (x[WIDTH-1] ^ y[WIDTH-1]);
            smode  <= signed_mode;
            acc    <= '0;
            cnt    <= CW'(ITER);
        end else if (state == BUSY) begin
            acc    <= acc_next;
            mplier <= mplier >> STEP;
            cnt    <= cnt - CW'(1);
            if (last) begin
                s   <= result;
                ovf <= ovf_next;
            end
        end
    end

endmodule

// File: tb/tb_seq_mul.sv
// tb/tb_seq_mul.sv - self-checking bench for seq_mul (32/1, 16/4, 16/8)

module tb_seq_mul;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0, out_ready = 1'b1, signed_mode = 1'b0;
    logic [31:0] x = '0, y = '0;
    logic        in_ready, out_valid, ovf;
    logic [63:0] s;

    logic        in_valid16 = 1'b0, out_ready16 = 1'b1, sm16 = 1'b0;
    logic [15:0] x16 = '0, y16 = '0;
    logic        in_ready4, out_valid4, ovf4, in_ready8, out_valid8, ovf8;
    logic [31:0] s4, s8;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    seq_mul #(.WIDTH(32), .STEP(1)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .x(x), .y(y), .signed_mode(signed_mode), .out_valid(out_valid),
        .out_ready(out_ready), .s(s), .ovf(ovf)
    );

    seq_mul #(.WIDTH(16), .STEP(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid16), .in_ready(in_ready4),
        .x(x16), .y(y16), .signed_mode(sm16), .out_valid(out_valid4),
        .out_ready(out_ready16), .s(s4), .ovf(ovf4)
    );

    seq_mul #(.WIDTH(16), .STEP(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid16), .in_ready(in_ready8),
        .x(x16), .y(y16), .signed_mode(sm16), .out_valid(out_valid8),
        .out_ready(out_ready16), .s(s8), .ovf(ovf8)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference product from plain integer arithmetic: {ovf, s}.
    function automatic logic [64:0] ref_mul(input logic [31:0] a, input logic [31:0] b,
                                            input logic sm);
        longint          ps;
        longint unsigned pu;
        if (sm) begin
            ps = longint'($signed(a)) * longint'($signed(b));
            return {(ps > 64'sd2147483647) || (ps < -64'sd2147483648), ps};
        end
        pu = {32'b0, a} * {32'b0, b};
        return {pu > 64'hFFFF_FFFF, pu};
    endfunction

    // Transaction-level model of the 32-bit instance: accept when idle,
    // result appears 32 edges later, held until consumed.
    int          m_phase = 0;
    int          m_left = 0;
    logic        m_live = 1'b0;
    logic [63:0] m_s = '0, m_pend_s = '0;
    logic        m_ovf = 1'b0, m_pend_ovf = 1'b0;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_phase <= 0;
            m_s     <= '0;
            m_ovf   <= 1'b0;
            m_live  <= 1'b1;
        end else begin
            case (m_phase)
                0: if (in_valid) begin
                    m_phase <= 1;
                    m_left  <= 32;
                    {m_pend_ovf, m_pend_s} <= ref_mul(x, y, signed_mode);
                end
                1: if (m_left == 1) begin
                    m_phase <= 2;
                    m_s     <= m_pend_s;
                    m_ovf   <= m_pend_ovf;
                end else begin
                    m_left <= m_left - 1;
                end
                default: if (out_ready) m_phase <= 0;
            endcase
        end
    end

    always @(negedge clk) begin
        if (m_live) begin
            chk("cyc_in_ready", in_ready, m_phase == 0);
            chk("cyc_out_valid", out_valid, m_phase == 2);
            chk("cyc_s", s, m_s);
            chk("cyc_ovf", ovf, m_ovf);
        end
    end

    task automatic run32(input logic [31:0] a, input logic [31:0] b, input logic sm,
                         input logic [63:0] es, input logic eo, input string nm);
        int n;
        x = a; y = b; signed_mode = sm; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        x = $urandom; y = $urandom; signed_mode = ~sm;
        n = 0;
        while (!out_valid && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk({nm, "_latency"}, n, 32);
        chk({nm, "_s"}, s, es);
        chk({nm, "_ovf"}, ovf, eo);
        if (out_ready) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic run16(input logic [15:0] a, input logic [15:0] b, input logic sm,
                         input logic [31:0] es, input logic eo, input string nm);
        int n, l4, l8;
        x16 = a; y16 = b; sm16 = sm; in_valid16 = 1'b1;
        @(posedge clk); #1;
        in_valid16 = 1'b0;
        x16 = 16'h1234; y16 = 16'h5678;
        n = 0; l4 = -1; l8 = -1;
        while ((l4 < 0 || l8 < 0) && n < 20) begin
            @(posedge clk); #1;
            n++;
            if (out_valid4 && l4 < 0) l4 = n;
            if (out_valid8 && l8 < 0) l8 = n;
        end
        chk({nm, "_lat_step4"}, l4, 4);
        chk({nm, "_lat_step8"}, l8, 2);
        chk({nm, "_s_step4"}, s4, es);
        chk({nm, "_ovf_step4"}, ovf4, eo);
        chk({nm, "_s_step8"}, s8, es);
        chk({nm, "_ovf_step8"}, ovf8, eo);
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        chk("reset_in_ready", in_ready, 1);
        chk("reset_out_valid", out_valid, 0);
        chk("reset_s", s, 0);
        chk("reset_ovf", ovf, 0);

        run32(32'd0, 32'd1111, 1'b0, 64'd0, 1'b0, "zero");
        run32(32'd100, 32'd505000, 1'b0, 64'd50500000, 1'b0, "u_small");
        run32(32'd1111111111, 32'd1111111111, 1'b0, 64'd1234567900987654321, 1'b1, "u_big");
        run32(32'hFFFF_FFFD, 32'd5, 1'b1, 64'hFFFF_FFFF_FFFF_FFF1, 1'b0, "s_neg");
        run32(32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000, 1'b1, "s_min");

        out_ready = 1'b0;
        run32(32'd100, 32'd505000, 1'b0, 64'd50500000, 1'b0, "bp");
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; x = i + 3; y = 32'd9; signed_mode = 1'b0;
            @(posedge clk); #1;
            chk("bp_hold_s", s, 64'd50500000);
            chk("bp_hold_ovf", ovf, 0);
            chk("bp_in_ready", in_ready, 0);
            chk("bp_out_valid", out_valid, 1);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_release_in_ready", in_ready, 1);
        chk("bp_release_out_valid", out_valid, 0);

        x = 32'd123; y = 32'd456; signed_mode = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("midrst_in_ready", in_ready, 1);
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_s", s, 0);
        chk("midrst_ovf", ovf, 0);
        run32(32'd7, 32'd6, 1'b0, 64'd42, 1'b0, "after_rst");

        run16(16'hFFFF, 16'hFFFF, 1'b1, 32'h0000_0001, 1'b0, "w16_s_m1");
        run16(16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE_0001, 1'b1, "w16_u_max");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
